stream_symbol_unpacker: RTL and testbench

- Read-side consumer of stream_data_sync_buffer in the clk domain.
- Pops 128-bit words from the FIFO read port and parses a header word carrying the symbol count.
- Serialises the following payload words into 2-bit nucleotide symbols, one per cycle, over a valid/ready handshake into the Smith-Waterman array loader.
- Marks the final symbol of each stream with sym_last.

---
 rtl/sw_stream_pkg.sv | 23 ++
 rtl/sym_shift_reg.sv | 32 +++
 rtl/stream_symbol_unpacker.sv | 121 ++++++++++++
 tb/tb_stream_symbol_unpacker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_stream_pkg.sv
// Shared widths, FSM encoding and nucleotide codes
// for the FIFO-to-symbol read path.
package sw_stream_pkg;
  localparam int WORD_W = 128;
  localparam int SYM_W  = 2;
  localparam int LEN_W  = 32;
  localparam int SYMS_PER_WORD = WORD_W / SYM_W;

  typedef enum logic [2:0] {
    HDR_REQ,
    HDR_CAP,
    DAT_REQ,
    DAT_CAP,
    EMIT
  } unpk_state_e;

  typedef enum logic [1:0] {
    NUC_A = 2'd0,
    NUC_C = 2'd1,
    NUC_G = 2'd2,
    NUC_T = 2'd3
  } nuc_e;
endpackage

// File: rtl/sym_shift_reg.sv
// Word-wide shift register, loads a FIFO word and
// drops one symbol off the bottom per shift.
module sym_shift_reg #(
  parameter int WORD_W = sw_stream_pkg::WORD_W,
  parameter int SYM_W  = sw_stream_pkg::SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [SYM_W-1:0]  lsb
);
  logic [WORD_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = din;
    else if (shift)
      sr_d = sr_q >> SYM_W;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

  assign lsb = sr_q[SYM_W-1:0];
endmodule

// File: rtl/stream_symbol_unpacker.sv
// Pops header + payload words from the sync FIFO and
// streams 2-bit nucleotide symbols to the SW loader.
module stream_symbol_unpacker #(
  parameter int WORD_W = sw_stream_pkg::WORD_W,
  parameter int SYM_W  = sw_stream_pkg::SYM_W,
  parameter int LEN_W  = sw_stream_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [SYM_W-1:0]  sym,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              sym_last,
  output logic [LEN_W-1:0]  len,
  output logic              len_valid,
  output logic              busy
);
  import sw_stream_pkg::*;

  localparam int SPW  = WORD_W / SYM_W;
  localparam int RW_W = $clog2(SPW + 1);

  unpk_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_total_q, rem_total_d;
  logic [RW_W-1:0]  rem_word_q, rem_word_d;
  logic             len_valid_q, len_valid_d;
  logic             busy_q, busy_d;
  logic             sr_load, sr_shift, hs;
  logic [LEN_W-1:0] hdr_n;
  logic             req_st;

  assign hdr_n  = fifo_dout[LEN_W-1:0];
  assign req_st = (state_q == HDR_REQ)
               || (state_q == DAT_REQ);
  // no pop while held in reset, so the FIFO is never drained blindly
  assign fifo_rd_en = rst && req_st && !fifo_empty;
  assign hs = (state_q == EMIT) && sym_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_total_d = rem_total_q;
    rem_word_d  = rem_word_q;
    len_valid_d = 1'b0;
    busy_d      = busy_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    unique case (state_q)
      HDR_REQ: if (fifo_rd_en) state_d = HDR_CAP;
      HDR_CAP: begin
        len_d       = hdr_n;
        len_valid_d = 1'b1;
        rem_total_d = hdr_n;
        busy_d      = (hdr_n != '0);
        state_d     = (hdr_n != '0) ? DAT_REQ : HDR_REQ;
      end
      DAT_REQ: if (fifo_rd_en) state_d = DAT_CAP;
      DAT_CAP: begin
        sr_load = 1'b1;
        if (rem_total_q > LEN_W'(SPW))
          rem_word_d = RW_W'(SPW);
        else
          rem_word_d = rem_total_q[RW_W-1:0];
        state_d = EMIT;
      end
      EMIT: if (hs) begin
        sr_shift    = 1'b1;
        rem_total_d = rem_total_q - LEN_W'(1);
        rem_word_d  = rem_word_q - RW_W'(1);
        if (rem_total_q == LEN_W'(1)) begin
          state_d = HDR_REQ;
          busy_d  = 1'b0;
        end else if (rem_word_q == RW_W'(1)) begin
          state_d = DAT_REQ;
        end
      end
      default: state_d = HDR_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HDR_REQ;
      len_q       <= '0;
      rem_total_q <= '0;
      rem_word_q  <= '0;
      len_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_total_q <= rem_total_d;
      rem_word_q  <= rem_word_d;
      len_valid_q <= len_valid_d;
      busy_q      <= busy_d;
    end
  end

  sym_shift_reg #(
    .WORD_W(WORD_W),
    .SYM_W (SYM_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (fifo_dout),
    .lsb  (sym)
  );

  assign sym_valid = (state_q == EMIT);
  assign sym_last  = sym_valid
                  && (rem_total_q == LEN_W'(1));
  assign len       = len_q;
  assign len_valid = len_valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_stream_symbol_unpacker.sv
// Directed + randomized bench for stream_symbol_unpacker
// with a FIFO model and a symbol-list reference.
module tb_stream_symbol_unpacker;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [1:0]   sym;
  logic         sym_valid, sym_last;
  logic         sym_ready = 1'b1;
  logic [31:0]  len;
  logic         len_valid, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int lv_cnt = 0;
  int recv = 0;
  int last_rd_cyc = -100;

  logic [127:0] fq[$];
  logic [127:0] pend[$];
  logic [2:0]   exp_q[$];
  logic [31:0]  len_exp[$];
  int           hs_cyc[$];

  bit pop_req = 0;
  bit rdy_mode = 0;
  bit prev_stall = 0, prev_valid = 0;
  bit prev_rd = 0, prev_lv = 0;
  logic [1:0]   prev_sym = '0;
  logic         prev_last = 1'b0;
  logic [1:0]   last_sym_seen = '0;
  logic [127:0] last_word = '0;

  stream_symbol_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last),
    .len       (len),
    .len_valid (len_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // FIFO model: non-FWFT, data appears the cycle after a pop
  always @(negedge clk) pop_req = fifo_rd_en;
  always @(posedge clk) begin
    if (pop_req && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
      pop_cnt++;
    end
    #1 fifo_empty = (fq.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    sym_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
      prev_valid = 0;
      prev_rd = 0;
      prev_lv = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(sym_valid), 1);
        chk("stall_sym", 64'(sym), 64'(prev_sym));
        chk("stall_last", 64'(sym_last), 64'(prev_last));
      end
      if (sym_valid && !prev_valid)
        chk("rd_to_valid", 64'(cyc - last_rd_cyc), 2);
      if (fifo_rd_en) begin
        chk("rd_while_empty", 64'(fifo_empty), 0);
        chk("rd_back2back", 64'(prev_rd), 0);
        last_rd_cyc = cyc;
      end
      if (len_valid) begin
        lv_cnt++;
        chk("lv_pulse", 64'(prev_lv), 0);
        if (len_exp.size() == 0)
          chk("len_unexpected", 0, 1);
        else begin
          chk("len", 64'(len), 64'(len_exp[0]));
          if (len_exp[0] == 0)
            chk("busy_n0", 64'(busy), 0);
          void'(len_exp.pop_front());
        end
      end
      if (sym_valid && sym_ready) begin
        chk("busy_emit", 64'(busy), 1);
        if (exp_q.size() == 0)
          chk("sym_unexpected", 0, 1);
        else begin
          chk("sym", 64'(sym), 64'(exp_q[0][1:0]));
          chk("sym_last", 64'(sym_last), 64'(exp_q[0][2]));
          void'(exp_q.pop_front());
        end
        hs_cyc.push_back(cyc);
        recv++;
        if (sym_last) last_sym_seen = sym;
      end
      prev_stall = sym_valid && !sym_ready;
      prev_sym = sym;
      prev_last = sym_last;
      prev_valid = sym_valid;
      prev_rd = fifo_rd_en;
      prev_lv = len_valid;
    end
  end

  // Reference: symbol k is bits [2k+1:2k] of payload word k/64
  task automatic build(input int n, input bit fix39);
    logic [127:0] w, t;
    logic [127:0] words[$];
    w = rnd128();
    w[31:0] = n;
    pend.push_back(w);
    len_exp.push_back(n);
    for (int i = 0; i < (n + 63) / 64; i++) begin
      w = rnd128();
      if (fix39 && i == 0) w[7:0] = 8'h39;
      words.push_back(w);
      pend.push_back(w);
      last_word = w;
    end
    for (int k = 0; k < n; k++) begin
      t = words[k / 64] >> (2 * (k % 64));
      exp_q.push_back({1'(k == n - 1), t[1:0]});
    end
  endtask

  task automatic push_pend(input int k);
    @(posedge clk);
    #2;
    for (int i = 0; i < k; i++)
      if (pend.size() > 0) fq.push_back(pend.pop_front());
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic wait_done(input string tag,
                           input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (c < budget &&
               (exp_q.size() != 0 || len_exp.size() != 0 ||
                fq.size() != 0 || busy || sym_valid ||
                fifo_rd_en));
    chk({tag, "_left"}, 64'(exp_q.size() + len_exp.size()), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic wait_recv(input int target, input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (c < budget && recv < target);
    chk("recv_reached", 64'(recv >= target), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0, bad;

    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'({fifo_rd_en, sym, sym_valid, sym_last,
                           len, len_valid, busy}), 0);
    rst = 1;

    // N=3, payload ...39 -> symbols 1,2,3
    p0 = pop_cnt; l0 = lv_cnt; hs_cyc.delete();
    build(3, 1);
    push_pend(2);
    wait_done("t1", 200);
    chk("t1_pops", 64'(pop_cnt - p0), 2);
    chk("t1_lv", 64'(lv_cnt - l0), 1);
    chk("t1_len", 64'(len), 3);
    chk("t1_nsym", 64'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3)
      chk("t1_consec", 64'(hs_cyc[2] - hs_cyc[0]), 2);

    // N=64 then N=65
    p0 = pop_cnt; hs_cyc.delete();
    build(64, 0);
    build(65, 0);
    push_pend(pend.size());
    wait_done("t2", 600);
    chk("t2_pops", 64'(pop_cnt - p0), 5);
    chk("t2_nsym", 64'(hs_cyc.size()), 129);
    if (hs_cyc.size() == 129) begin
      bad = 0;
      for (int i = 1; i < 64; i++)
        if (hs_cyc[i] - hs_cyc[i-1] != 1) bad++;
      for (int i = 65; i < 128; i++)
        if (hs_cyc[i] - hs_cyc[i-1] != 1) bad++;
      chk("t2_contig", 64'(bad), 0);
      chk("t2_word_gap", 64'(hs_cyc[128] - hs_cyc[127]), 3);
    end
    chk("t2_last_sym", 64'(last_sym_seen), 64'(last_word[1:0]));

    // N=0 then N=2
    p0 = pop_cnt; l0 = lv_cnt; hs_cyc.delete();
    build(0, 0);
    build(2, 0);
    push_pend(pend.size());
    wait_done("t3", 200);
    chk("t3_pops", 64'(pop_cnt - p0), 3);
    chk("t3_lv", 64'(lv_cnt - l0), 2);
    chk("t3_len", 64'(len), 2);
    chk("t3_nsym", 64'(hs_cyc.size()), 2);

    // N=100 with random backpressure
    rdy_mode = 1; hs_cyc.delete();
    build(100, 0);
    push_pend(pend.size());
    wait_done("t4", 2000);
    chk("t4_nsym", 64'(hs_cyc.size()), 100);
    rdy_mode = 0;

    // writer stalls before the second payload word
    hs_cyc.delete();
    build(100, 0);
    push_pend(2);
    repeat (75) @(negedge clk);
    #1;
    chk("t5_bubble_valid", 64'(sym_valid), 0);
    chk("t5_bubble_rd", 64'(fifo_rd_en), 0);
    chk("t5_bubble_busy", 64'(busy), 1);
    push_pend(1);
    wait_done("t5", 500);
    chk("t5_nsym", 64'(hs_cyc.size()), 100);

    // random lengths, random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      build($urandom_range(1, 200), 0);
      push_pend(pend.size());
      wait_done("rand", 3000);
    end
    rdy_mode = 0;

    // reset during the 10th symbol of N=64
    build(64, 0);
    push_pend(pend.size());
    wait_recv(recv + 10, 500);
    rst = 0;
    fq.delete();
    pend.delete();
    fifo_empty = 1;
    @(negedge clk);
    #1;
    chk("t6_reset_outs", 64'({fifo_rd_en, sym, sym_valid, sym_last,
                              len, len_valid, busy}), 0);
    exp_q.delete();
    len_exp.delete();
    rst = 1;
    hs_cyc.delete();
    build(4, 0);
    push_pend(pend.size());
    wait_done("t6", 200);
    chk("t6_len", 64'(len), 4);
    chk("t6_nsym", 64'(hs_cyc.size()), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
